// File: rtl/event_sync_arbiter_pkg.sv
// Shared types and helpers for the event synchronizer arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package event_sync_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/event_sync_arbiter_rr_pick.sv
// Round-robin selector: first requesting channel strictly after ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the pick.
module rr_pick
    import event_sync_pkg::*;
#(
    parameter int  N_CH = 4,
    localparam int CW   = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic            any,
    output logic [CW-1:0]   idx
);

    logic [CW-1:0] cand;

    // Walk ptr+1 .. ptr+N_CH (mod N_CH); the first hit wins, ptr itself is last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CW'((int'(ptr) + k) % N_CH);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/event_sync_arbiter.sv
// Counts synchronized event rises per channel and serializes them round-robin.
// Latency: rise sampled at edge k -> evt_valid after edge k+1; one event per 2 cycles max.
// Backpressure: offer held stable until evt_ready; counters absorb, saturate and flag overflow.
module event_sync_arbiter
    import event_sync_pkg::*;
#(
    parameter int  N_CH  = 4,
    parameter int  CNT_W = 4,
    localparam int CW    = ch_w(N_CH)
) (
    input  logic            outclk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] sync_evt,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CW-1:0]   evt_ch,
    output logic [N_CH-1:0] overflow,
    input  logic [N_CH-1:0] clr_overflow,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  prev;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  nz;
    logic [N_CH-1:0]  acc_hit;
    logic [N_CH-1:0]  ovf_set;
    logic [CW-1:0]    ptr;
    logic             pick_any;
    logic [CW-1:0]    pick_idx;
    logic             load;
    logic             accept;
    state_t           state;
    state_t           state_nxt;

    assign rise      = sync_evt & ~prev;
    assign evt_valid = (state == OFFER);

    // Edge-detect history; cleared by reset so a level high at release counts once.
    always_ff @(posedge outclk or negedge reset_n) begin
        if (!reset_n) prev <= '0;
        else          prev <= sync_evt;
    end

    // Per-channel pending flags, accept decode and overflow detection.
    always_comb begin
        nz      = '0;
        acc_hit = '0;
        ovf_set = '0;
        for (int i = 0; i < N_CH; i++) begin
            nz[i]      = (cnt[i] != '0);
            acc_hit[i] = accept && (evt_ch == CW'(i));
            ovf_set[i] = rise[i] && !acc_hit[i] && (cnt[i] == CNT_MAX);
        end
        busy = (|nz) | evt_valid;
    end

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req (nz),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next state: pick from registered counts in IDLE, hold the offer until ready.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = OFFER;
                    load      = 1'b1;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_nxt = IDLE;
                    accept    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge outclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Offered channel and round-robin pointer; ptr starts at the top so ch0 goes first.
    always_ff @(posedge outclk or negedge reset_n) begin
        if (!reset_n) begin
            evt_ch <= '0;
            ptr    <= CW'(N_CH - 1);
        end else begin
            if (load)   evt_ch <= pick_idx;
            if (accept) ptr    <= evt_ch;
        end
    end

    // Pending counters: rise and accept on the same channel cancel; saturate at max.
    always_ff @(posedge outclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (rise[i] && !acc_hit[i]) begin
                    if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                end else if (!rise[i] && acc_hit[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky overflow; a fresh overflow beats a clear in the same cycle.
    always_ff @(posedge outclk or negedge reset_n) begin
        if (!reset_n) overflow <= '0;
        else          overflow <= (overflow & ~clr_overflow) | ovf_set;
    end

endmodule

// File: tb/tb_event_sync_arbiter.sv
module tb_event_sync_arbiter;

    localparam int N    = 4;
    localparam int MAXC = 15;

    logic         outclk = 1'b0;
    logic         reset_n;
    logic [N-1:0] sync_evt;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_ch;
    logic [N-1:0] overflow;
    logic [N-1:0] clr_overflow;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural reference: per-channel pending counts and the single outstanding offer.
    int       m_cnt [N];
    bit       m_prev[N];
    bit [N-1:0] m_ovf;
    bit       m_valid;
    int       m_ch;
    int       m_last;
    int       dut_grants[$];

    event_sync_arbiter #(.N_CH(N), .CNT_W(4)) dut (
        .outclk       (outclk),
        .reset_n      (reset_n),
        .sync_evt     (sync_evt),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy)
    );

    always #5 outclk = ~outclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        bit b;
        b = m_valid;
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) b = 1'b1;
        return b;
    endfunction

    function automatic int grant_at(input int i);
        if (i < dut_grants.size()) return dut_grants[i];
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_prev[i] = 1'b0;
        end
        m_ovf   = '0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_last  = N - 1;
    endtask

    // One clock edge of the reference, from the inputs currently driven.
    task automatic model_step();
        bit acc;
        bit found;
        int pick;
        int c;
        bit r;
        acc   = m_valid && evt_ready;
        found = 1'b0;
        pick  = 0;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && m_cnt[c] > 0) begin
                found = 1'b1;
                pick  = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            r = sync_evt[i] && !m_prev[i];
            m_cnt[i] = m_cnt[i] + int'(r) - int'(acc && m_ch == i);
            m_ovf[i] = m_ovf[i] && !clr_overflow[i];
            if (m_cnt[i] > MAXC) begin
                m_cnt[i] = MAXC;
                m_ovf[i] = 1'b1;
            end
            m_prev[i] = sync_evt[i];
        end
        if (acc) begin
            m_valid = 1'b0;
            m_last  = m_ch;
        end else if (!m_valid && found) begin
            m_valid = 1'b1;
            m_ch    = pick;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, evt_valid, m_valid);
        check({tag, ".ch"},    evt_ch,    m_ch);
        check({tag, ".ovf"},   overflow,  m_ovf);
        check({tag, ".busy"},  busy,      m_busy());
    endtask

    task automatic cycle(input string tag);
        if (evt_valid === 1'b1 && evt_ready === 1'b1) dut_grants.push_back(int'(evt_ch));
        model_step();
        @(posedge outclk);
        #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        reset_n      = 1'b0;
        sync_evt     = '0;
        evt_ready    = 1'b0;
        clr_overflow = '0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge outclk);
        reset_n = 1'b1;
        dut_grants.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        sync_evt     = '0;
        evt_ready    = 1'b0;
        clr_overflow = '0;
        model_reset();

        // Reset state.
        apply_reset("rst");

        // Single pulse held 3 cycles on ch2 counts once.
        evt_ready = 1'b1;
        sync_evt  = 4'b0100;
        cycle("sp");
        check("sp.edge1_valid", evt_valid, 1'b0);
        cycle("sp");
        check("sp.edge2_valid", evt_valid, 1'b1);
        cycle("sp");
        sync_evt = '0;
        repeat (6) cycle("sp");
        check("sp.count", dut_grants.size(), 1);
        check("sp.ch", grant_at(0), 2);
        check("sp.busy_end", busy, 1'b0);

        // Round-robin from fresh reset: all four channels at once.
        apply_reset("rst2");
        evt_ready = 1'b1;
        sync_evt  = 4'b1111;
        cycle("rr");
        sync_evt = '0;
        repeat (12) cycle("rr");
        check("rr.count", dut_grants.size(), 4);
        for (int i = 0; i < 4; i++) check("rr.order", grant_at(i), i);
        check("rr.busy_end", busy, 1'b0);

        // Backpressure: ch1 and ch3 pending, consumer stalled.
        dut_grants.delete();
        evt_ready = 1'b0;
        sync_evt  = 4'b1010;
        cycle("bp");
        sync_evt = '0;
        cycle("bp");
        for (int i = 0; i < 10; i++) begin
            cycle("bp");
            check("bp.hold", {evt_valid, evt_ch}, 3'b101);
        end
        evt_ready = 1'b1;
        repeat (6) cycle("bp");
        check("bp.count", dut_grants.size(), 2);
        check("bp.first", grant_at(0), 1);
        check("bp.second", grant_at(1), 3);

        // Rise and accept on ch0 in the same cycle leaves one pending.
        dut_grants.delete();
        evt_ready = 1'b0;
        sync_evt  = 4'b0001;
        cycle("sim");
        sync_evt = '0;
        cycle("sim");
        check("sim.offer", {evt_valid, evt_ch}, 3'b100);
        sync_evt  = 4'b0001;
        evt_ready = 1'b1;
        cycle("sim");
        sync_evt = '0;
        repeat (5) cycle("sim");
        check("sim.count", dut_grants.size(), 2);
        check("sim.again", grant_at(1), 0);

        // Overflow on ch3: 16 rises with the consumer stalled.
        dut_grants.delete();
        evt_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sync_evt = 4'b1000;
            cycle("ovf");
            sync_evt = '0;
            cycle("ovf");
        end
        check("ovf.set", overflow, 4'b1000);
        sync_evt     = 4'b1000;
        clr_overflow = 4'b1000;
        cycle("ovf_clr_rise");
        check("ovf.clr_vs_new", overflow[3], 1'b1);
        sync_evt     = '0;
        clr_overflow = 4'b1000;
        cycle("ovf_clr");
        clr_overflow = '0;
        check("ovf.cleared", overflow, 4'b0000);
        evt_ready = 1'b1;
        repeat (36) cycle("ovf_drain");
        check("ovf.drained", dut_grants.size(), 15);
        check("ovf.busy_end", busy, 1'b0);

        // Randomized traffic with bursty stalls and occasional clears.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) sync_evt = 4'($urandom_range(0, 15));
            evt_ready    = ((i / 40) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cycle("rnd");
        end
        clr_overflow = '0;

        // Reset during an offer with counts pending.
        evt_ready = 1'b0;
        sync_evt  = 4'b0011;
        cycle("mid");
        sync_evt = '0;
        repeat (3) cycle("mid");
        check("mid.pre_valid", evt_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid.valid_drop", evt_valid, 1'b0);
        check("mid.busy_drop", busy, 1'b0);
        check("mid.ovf_drop", overflow, 4'b0000);
        model_reset();
        @(negedge outclk);
        reset_n = 1'b1;
        dut_grants.delete();
        evt_ready = 1'b1;
        repeat (10) cycle("post");
        check("post.no_offers", dut_grants.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/event_sync_arbiter.md
Name: event_sync_arbiter

Overview:
Collects event pulses from N_CH async-to-outclk pulse synchronizers and counts pending events per channel. Serializes the events to one consumer over a valid/ready handshake, with round-robin fairness. Sits directly downstream of the per-channel synchronizer instances, in the outclk domain. Flags per-channel counter overflow as sticky status.

Parameters:
N_CH, 4, number of synchronized event channels (2..16)
CNT_W, 4, width of each per-channel pending counter; saturates at 2^CNT_W-1

Ports:
outclk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
sync_evt  input  N_CH  synchronizer outputs, already in outclk domain; a high level may last more than 1 cycle
evt_valid  output  1  an event is offered to the consumer
evt_ready  input  1  consumer accepts the offered event
evt_ch  output  $clog2(N_CH) (min 1)  channel index of the offered event
overflow  output  N_CH  sticky per-channel overflow flags
clr_overflow  input  N_CH  per-channel overflow clear, single-cycle
busy  output  1  any pending count nonzero, or evt_valid high

Behaviour:
- Reset (asynchronous, immediate):
  - evt_valid=0, evt_ch=0, overflow=0, busy=0.
  - All counters=0, edge-detect history=0, RR pointer=N_CH-1 (so ch0 has first priority), FSM=IDLE.
  - Pending events are discarded; a reset mid-offer drops evt_valid at once.
- Edge detect, per channel:
  - rise[i] = sync_evt[i] & ~prev[i]; prev registered each cycle.
  - A level held high counts once.
  - A level that is high at reset release counts as one event.
- Pending counter cnt[i]:
  - +1 on rise[i].
  - -1 on accept of channel i (evt_valid & evt_ready & evt_ch==i).
  - rise and accept in the same cycle: net unchanged.
  - rise at cnt==max with no accept: cnt holds at max, overflow[i] set; that event is lost.
- overflow[i]:
  - Cleared by clr_overflow[i].
  - A new overflow in the same cycle as the clear wins (flag stays set).
- FSM, two states:
  - IDLE: if any cnt[i]>0, pick the first nonzero channel searching from ptr+1 upward, with wrap-around. Register evt_ch=pick, set evt_valid=1, go to OFFER.
  - OFFER: evt_valid and evt_ch are held stable until evt_ready. On accept: evt_valid=0, ptr=evt_ch, decrement that channel's counter, go to IDLE.
  - evt_ready while in IDLE is ignored.
- Latency:
  - A rise sampled at edge k gives cnt=1 after edge k.
  - evt_valid is high after edge k+1 (2 edges end-to-end) when the FSM is IDLE.
  - Throughput: at most 1 event per 2 cycles.
- Fairness: with all channels continuously pending, grants rotate 0,1,...,N_CH-1,0,...
- busy is combinational: OR of (cnt!=0) and evt_valid.

Decomposition:
- Package event_sync_pkg:
  - FSM state enum {IDLE, OFFER}.
  - Function ch_w(n), returning max(1, $clog2(n)).
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: req mask N_CH, ptr.
  - Outputs: any, idx.
- All other state lives in event_sync_arbiter.

Test Plan:
- Single pulse: after reset, sync_evt[2] high for 3 cycles, evt_ready=1 → exactly one evt_valid with evt_ch=2, starting 2 edges after first sample; busy falls afterwards.
- Round-robin: sync_evt=4'b1111 pulse, evt_ready=1 → grants in order ch 0,1,2,3; each counter ends at 0.
- Backpressure: events pending on ch1 and ch3, evt_ready=0 for 10 cycles → evt_valid=1 and evt_ch=1 stable throughout; on ready, ch1 is accepted, then ch3 is offered next.
- Simultaneous rise and accept on ch0 with cnt=1 → cnt stays 1; a second offer of ch0 follows.
- Overflow, CNT_W=4: 16 rises on ch3 with ready=0 → cnt=15, overflow[3]=1. Then clr_overflow[3] in the same cycle as another rise → overflow[3] stays 1. A clear alone → 0.
- Reset mid-operation: assert reset_n=0 while evt_valid=1 with pending counts → evt_valid=0 immediately. After release with sync_evt=0 → no offers; overflow=0.
